dm_arbiter: RTL

- Two-port arbiter that shares the single-port data memory (DM) between two requesters.
- Port 0 is the CPU load/store path; port 1 is a loader/debug master that preloads or inspects DM.
- Sits between both masters and the DM instance, driving DM_Address, DM_enable and DM_Write_Data, and sampling DM_Read_Data.
- Uses round-robin arbitration, bounded lock bursts and a registered response with an ack pulse.

---
 rtl/dm_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter sharing one single-port data memory between the CPU
// (port 0) and a loader/debug master (port 1). Define DM_ARB_STATS_EN for grant/conflict counters.
module dm_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              lock0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] DM_Address,
  output logic              DM_enable,
  output logic [DATA_W-1:0] DM_Write_Data,
  input  logic [DATA_W-1:0] DM_Read_Data
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [15:0]       stat_conflict
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              lock_own, gnt_port, acc;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    burst_d  = burst_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    lock_own = owner_q ? lock1 : lock0;
    gnt_port = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (req0 || req1) begin
          // On a tie the locked owner keeps the memory until its burst budget runs out
          if (req0 && req1)
            gnt_port = (lock_own && (burst_q < BMAX)) ? owner_q : ~last_q;
          else
            gnt_port = req1;
          state_d = ACCESS;
          owner_d = gnt_port;
          last_d  = gnt_port;
          if ((gnt_port == owner_q) && lock_own)
            burst_d = (burst_q == BMAX) ? burst_q : burst_q + 1'b1;
          else
            burst_d = BW'(1);
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!owner_q) begin
          ack0_d = 1'b1;
          if (!we0) rdata0_d = DM_Read_Data;
        end else begin
          ack1_d = 1'b1;
          if (!we1) rdata1_d = DM_Read_Data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      burst_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Gating with rst keeps a reset that lands mid-access from committing the write
  assign acc           = (state_q == ACCESS) && rst;
  assign DM_Address    = acc ? (owner_q ? addr1 : addr0) : '0;
  assign DM_Write_Data = acc ? (owner_q ? wdata1 : wdata0) : '0;
  assign DM_enable     = acc && (owner_q ? we1 : we0);

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

`ifdef DM_ARB_STATS_EN
  logic [15:0] sg0_q, sg1_q, sc_q;
  logic        arb_st, gnt_ev;

  assign arb_st = (state_q == IDLE) || (state_q == RESP);
  assign gnt_ev = arb_st && (state_d == ACCESS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sg0_q <= '0;
      sg1_q <= '0;
      sc_q  <= '0;
    end else begin
      if (gnt_ev && !owner_d && (sg0_q != 16'hFFFF)) sg0_q <= sg0_q + 16'd1;
      if (gnt_ev && owner_d && (sg1_q != 16'hFFFF))  sg1_q <= sg1_q + 16'd1;
      if (arb_st && req0 && req1 && (sc_q != 16'hFFFF)) sc_q <= sc_q + 16'd1;
    end
  end

  assign stat_gnt0     = sg0_q;
  assign stat_gnt1     = sg1_q;
  assign stat_conflict = sc_q;
`endif

endmodule
